// File: rtl/fc_pkg.sv
// Shared constants, sizing helpers and FSM encoding for the FC weight
// stream servers (one server per fully-connected layer).
package fc_pkg;

    localparam int FC_WEIGHT_WIDTH = 8;
    localparam int FC_LANES        = 8;

    // Weight counts per layer: IN_FEATURE * OUT_FEATURE
    localparam int FC1_DEPTH = 360 * 160;
    localparam int FC2_DEPTH = 160 * 80;
    localparam int FC3_DEPTH = 80 * 40;

    // Number of packed words needed to cover depth weights, lanes per word
    function automatic int calc_rows(input int depth, input int lanes);
        return (depth + lanes - 1) / lanes;
    endfunction

    // Index width for n entries, never narrower than one bit
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_SERVE = 2'd2
    } srv_state_e;

endpackage

// File: rtl/wgt_bank_ram.sv
// One weight bank: a single write port used while loading and a
// synchronous read port used while serving. Contents are never cleared.
module wgt_bank_ram
    import fc_pkg::*;
#(
    parameter int WIDTH = FC_WEIGHT_WIDTH,
    parameter int ROWS  = 8,
    parameter int AW    = addr_width(ROWS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ROWS];

    // Write on load strobe, registered read on request; no reset so the
    // array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fc_wgt_stream_server.sv
// Responder side of the FC weight-read handshake. Weights are loaded
// serially into LANES banks, then served one packed word per request
// with one cycle of latency, rewinding automatically after every pass.
module fc_wgt_stream_server
    import fc_pkg::*;
#(
    parameter int WEIGHT_WIDTH = FC_WEIGHT_WIDTH,
    parameter int LANES        = FC_LANES,
    parameter int DEPTH        = FC1_DEPTH
) (
    input  logic                            clk1,
    input  logic                            rst,
    input  logic                            load_en,
    input  logic [WEIGHT_WIDTH-1:0]         load_data,
    input  logic                            start,
    input  logic                            rd_req,
    output logic [LANES*WEIGHT_WIDTH-1:0]   rd_data,
    output logic                            rd_valid,
    output logic                            loaded,
    output logic                            end_pass,
    output logic                            err
);

    localparam int ROWS   = calc_rows(DEPTH, LANES);
    localparam int ROW_W  = addr_width(ROWS);
    localparam int LANE_W = addr_width(LANES);

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'((DEPTH - 1) % LANES);
    localparam logic [LANE_W-1:0] MAX_LANE  = LANE_W'(LANES - 1);

    srv_state_e state;

    // Write pointer kept as (row, lane) so no divider is needed
    logic [LANE_W-1:0] wr_lane;
    logic [ROW_W-1:0]  wr_row;
    logic [ROW_W-1:0]  rd_ptr;

    logic              wr_en;
    logic              wr_last;
    logic              serve;
    logic [ROW_W-1:0]  rd_addr;
    logic              rd_last;
    logic [ROW_W-1:0]  rd_next;

    logic [WEIGHT_WIDTH-1:0] bank_q [LANES];

    // Decode of the current cycle: write strobe, whether a request is
    // answered, and which row it reads (a same-edge start forces row 0).
    always_comb begin
        wr_en   = (state == ST_LOAD) && load_en;
        wr_last = (wr_row == LAST_ROW) && (wr_lane == LAST_LANE);
        serve   = rd_req && ((state == ST_SERVE) || ((state == ST_READY) && start));
        rd_addr = start ? '0 : rd_ptr;
        rd_last = (rd_addr == LAST_ROW);
        rd_next = rd_last ? '0 : rd_addr + ROW_W'(1);
    end

    // Control FSM with pointers and registered handshake/status outputs
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state    <= ST_LOAD;
            wr_lane  <= '0;
            wr_row   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            loaded   <= 1'b0;
            end_pass <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= serve;
            end_pass <= serve && rd_last;

            case (state)
                ST_LOAD: begin
                    if (load_en) begin
                        if (wr_last) begin
                            loaded <= 1'b1;
                            state  <= ST_READY;
                        end else if (wr_lane == MAX_LANE) begin
                            wr_lane <= '0;
                            wr_row  <= wr_row + ROW_W'(1);
                        end else begin
                            wr_lane <= wr_lane + LANE_W'(1);
                        end
                    end
                    if (rd_req) begin
                        err <= 1'b1;
                    end
                end

                ST_READY: begin
                    if (load_en) begin
                        err <= 1'b1;
                    end
                    if (start) begin
                        state <= ST_SERVE;
                    end else if (rd_req) begin
                        err <= 1'b1;
                    end
                    if (serve) begin
                        rd_ptr <= rd_next;
                    end else if (start) begin
                        rd_ptr <= '0;
                    end
                end

                ST_SERVE: begin
                    if (load_en) begin
                        err <= 1'b1;
                    end
                    if (serve) begin
                        rd_ptr <= rd_next;
                    end else if (start) begin
                        rd_ptr <= '0;
                    end
                end

                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // One bank per lane; lanes of the final row past DEPTH are zeroed at
    // the output since those bank entries are never written.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam bit TAIL_LANE = (((ROWS - 1) * LANES) + g) >= DEPTH;

        wgt_bank_ram #(
            .WIDTH (WEIGHT_WIDTH),
            .ROWS  (ROWS),
            .AW    (ROW_W)
        ) u_bank (
            .clk   (clk1),
            .we    (wr_en && (wr_lane == LANE_W'(g))),
            .waddr (wr_row),
            .wdata (load_data),
            .re    (serve),
            .raddr (rd_addr),
            .rdata (bank_q[g])
        );

        assign rd_data[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
            (rd_valid && !(TAIL_LANE && end_pass)) ? bank_q[g] : '0;
    end

endmodule

// File: tb/tb_fc_wgt_stream_server.sv
// Directed bench for fc_wgt_stream_server with DEPTH=20, LANES=8.
// A behavioural model tracks what every output must be each cycle and a
// negedge process compares against it; literal checks pin the model.
module tb_fc_wgt_stream_server;

    localparam int W    = 8;
    localparam int L    = 8;
    localparam int D    = 20;
    localparam int DW   = L * W;
    localparam int ROWS = (D + L - 1) / L;

    localparam logic [63:0] WORD0 = 64'h0807060504030201;
    localparam logic [63:0] WORD1 = 64'h100F0E0D0C0B0A09;
    localparam logic [63:0] WORD2 = 64'h0000000014131211;

    logic          clk1;
    logic          rst;
    logic          load_en;
    logic [W-1:0]  load_data;
    logic          start;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          loaded;
    logic          end_pass;
    logic          err;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Model state
    logic [W-1:0]  wmem [D];
    int            m_cnt    = 0;
    bit            m_loaded = 1'b0;
    bit            m_armed  = 1'b0;
    int            m_row    = 0;
    bit            m_err    = 1'b0;
    bit            exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    bit            exp_end   = 1'b0;

    fc_wgt_stream_server #(
        .WEIGHT_WIDTH (W),
        .LANES        (L),
        .DEPTH        (D)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .load_en   (load_en),
        .load_data (load_data),
        .start     (start),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .loaded    (loaded),
        .end_pass  (end_pass),
        .err       (err)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then idle them
    task automatic apply_stimulus(input logic le, input logic [W-1:0] ld, input logic st, input logic rq);
        load_en   = le;
        load_data = ld;
        start     = st;
        rd_req    = rq;
        @(posedge clk1);
        #2;
        load_en   = 1'b0;
        load_data = '0;
        start     = 1'b0;
        rd_req    = 1'b0;
    endtask

    // Spec-level model: count loaded weights, then answer armed requests
    // with the next row of the loaded weight list, zero past the end.
    always @(posedge clk1 or posedge rst) begin : model
        logic [DW-1:0] word;
        int r;
        if (rst) begin
            m_cnt     <= 0;
            m_loaded  <= 1'b0;
            m_armed   <= 1'b0;
            m_row     <= 0;
            m_err     <= 1'b0;
            exp_valid <= 1'b0;
            exp_data  <= '0;
            exp_end   <= 1'b0;
        end else begin
            word = '0;
            r    = m_row;
            exp_valid <= 1'b0;
            exp_data  <= '0;
            exp_end   <= 1'b0;
            if (!m_loaded) begin
                if (load_en) begin
                    wmem[m_cnt] <= load_data;
                    m_cnt <= m_cnt + 1;
                    if (m_cnt + 1 == D) m_loaded <= 1'b1;
                end
                if (rd_req) m_err <= 1'b1;
            end else begin
                if (load_en) m_err <= 1'b1;
                if (start) begin
                    m_armed <= 1'b1;
                    r = 0;
                end
                if (rd_req && (m_armed || start)) begin
                    for (int i = 0; i < L; i++) begin
                        if (r * L + i < D) word[i*W +: W] = wmem[r * L + i];
                    end
                    exp_valid <= 1'b1;
                    exp_data  <= word;
                    exp_end   <= (r == ROWS - 1);
                    r = (r + 1) % ROWS;
                end else if (rd_req) begin
                    m_err <= 1'b1;
                end
                m_row <= r;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk1) begin
        if (cmp_en) begin
            check_output("cyc_rd_valid", 64'(rd_valid), 64'(exp_valid));
            check_output("cyc_rd_data",  64'(rd_data),  64'(exp_data));
            check_output("cyc_end_pass", 64'(end_pass), 64'(exp_end));
            check_output("cyc_loaded",   64'(loaded),   64'(m_loaded));
            check_output("cyc_err",      64'(err),      64'(m_err));
        end
    end

    initial begin
        rst = 1'b0;
        load_en = 1'b0;
        load_data = '0;
        start = 1'b0;
        rd_req = 1'b0;
        #1;
        rst = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk1);
        @(posedge clk1);
        #2;
        check_output("reset_rd_valid", 64'(rd_valid), 64'd0);
        check_output("reset_rd_data",  64'(rd_data),  64'd0);
        check_output("reset_loaded",   64'(loaded),   64'd0);
        check_output("reset_err",      64'(err),      64'd0);
        rst = 1'b0;

        // Load weights 1..20
        for (int k = 1; k <= D; k++) begin
            apply_stimulus(1'b1, W'(k), 1'b0, 1'b0);
            if (k == D - 1) check_output("loaded_before_last", 64'(loaded), 64'd0);
        end
        check_output("loaded_after_last", 64'(loaded), 64'd1);
        check_output("err_after_load",    64'(err),    64'd0);

        // Request in READY before start
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("ready_req_valid", 64'(rd_valid), 64'd0);
        check_output("ready_req_err",   64'(err),      64'd1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_output("err_sticky", 64'(err), 64'd1);

        // Start then a single read
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("start_no_valid", 64'(rd_valid), 64'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("single_valid", 64'(rd_valid), 64'd1);
        check_output("single_word0", 64'(rd_data),  WORD0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_output("idle_valid", 64'(rd_valid), 64'd0);
        check_output("idle_data",  64'(rd_data),  64'd0);

        // Full pass with tail padding, then wrap
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("pass_word0", 64'(rd_data),  WORD0);
        check_output("pass_end0",  64'(end_pass), 64'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("pass_word1", 64'(rd_data),  WORD1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("pass_word2", 64'(rd_data),  WORD2);
        check_output("pass_end2",  64'(end_pass), 64'd1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("wrap_word0", 64'(rd_data),  WORD0);
        check_output("wrap_end",   64'(end_pass), 64'd0);

        // Late load attempt must not disturb the store
        apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        check_output("late_load_err", 64'(err), 64'd1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("reread_word0", 64'(rd_data), WORD0);

        // Start colliding with a request at rd_ptr=2
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("pre_collide_word1", 64'(rd_data), WORD1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1);
        check_output("collide_word0", 64'(rd_data), WORD0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("post_collide_word1", 64'(rd_data), WORD1);

        // Asynchronous reset mid-serve
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("pre_reset_valid", 64'(rd_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_output("async_rd_valid", 64'(rd_valid), 64'd0);
        check_output("async_rd_data",  64'(rd_data),  64'd0);
        check_output("async_loaded",   64'(loaded),   64'd0);
        check_output("async_err",      64'(err),      64'd0);
        @(posedge clk1);
        #2;
        rst = 1'b0;
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("load_start_valid", 64'(rd_valid), 64'd0);
        check_output("load_start_err",   64'(err),      64'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("load_req_valid", 64'(rd_valid), 64'd0);
        check_output("load_req_err",   64'(err),      64'd1);

        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
